// File: rtl/sda_kernel_ctrl_reg_multi.sv
// Kernel control register file with NUM_ARGS 64-bit pointer arguments.
// It turns host run/status register accesses into the action go/done req/ack handshake.
module sda_kernel_ctrl_reg_multi #(
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_ARGS   = 2
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic                   reg_req,
    output logic                   reg_ack,
    input  logic                   reg_write_en,
    input  logic [ADDR_WIDTH-1:0]  reg_addr,
    input  logic [31:0]            reg_wdata,
    input  logic [3:0]             reg_wstrb,
    output logic [31:0]            reg_rdata,
    output logic                   go_r,
    input  logic                   go_a,
    input  logic                   done_r,
    output logic                   done_a,
    output logic                   interrupt,
    output logic [64*NUM_ARGS-1:0] arg_base
);

    localparam int WIDX_W = ADDR_WIDTH - 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GO_REQ   = 3'd1,
        GO_REL   = 3'd2,
        RUN      = 3'd3,
        DONE_ACK = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic        reg_ack_reg;
    logic        ap_start_reg, ap_done_reg, ap_ready_reg, auto_restart_reg;
    logic        gie_reg, interrupt_reg;
    logic [1:0]  ier_reg, isr_reg;
    logic [63:0] arg_reg      [NUM_ARGS];
    logic [63:0] arg_snap_reg [NUM_ARGS];

    logic [WIDX_W-1:0]   widx;
    logic                unused_addr_lsbs;
    logic                wr_acc, rd_acc;
    logic                hit_ctrl, hit_gie, hit_ier, hit_isr;
    logic [NUM_ARGS-1:0] hit_lo, hit_hi;
    logic                start_set, ctrl_rd, ready_evt, done_evt, launch, ap_idle;
    logic [1:0]          isr_toggle;
    logic [31:0]         rd_mux;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    assign widx             = reg_addr[ADDR_WIDTH-1:2];
    assign unused_addr_lsbs = ^reg_addr[1:0];
    assign wr_acc           = reg_req & reg_ack_reg & reg_write_en;
    assign rd_acc           = reg_req & reg_ack_reg & ~reg_write_en;

    assign hit_ctrl = (widx == WIDX_W'(0));
    assign hit_gie  = (widx == WIDX_W'(1));
    assign hit_ier  = (widx == WIDX_W'(2));
    assign hit_isr  = (widx == WIDX_W'(3));

    generate
        for (genvar gi = 0; gi < NUM_ARGS; gi++) begin : g_arg
            assign hit_lo[gi] = (widx == WIDX_W'(4 + 2*gi));
            assign hit_hi[gi] = (widx == WIDX_W'(5 + 2*gi));
            assign arg_base[64*gi +: 64] = arg_snap_reg[gi];
        end
    endgenerate

    assign start_set  = wr_acc & hit_ctrl & reg_wstrb[0] & reg_wdata[0];
    assign ctrl_rd    = rd_acc & hit_ctrl;
    assign ready_evt  = (state_reg == GO_REQ) & go_a;
    assign done_evt   = (state_reg == RUN) & done_r;
    assign launch     = (state_reg == IDLE) & ap_start_reg;
    assign ap_idle    = (state_reg == IDLE);
    assign isr_toggle = (wr_acc & hit_isr & reg_wstrb[0]) ? reg_wdata[1:0] : 2'b00;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_reg <= IDLE;
        else           state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (ap_start_reg) state_next = GO_REQ;
            GO_REQ:   if (go_a)         state_next = GO_REL;
            GO_REL:   if (!go_a)        state_next = RUN;
            RUN:      if (done_r)       state_next = DONE_ACK;
            DONE_ACK: if (!done_r)      state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_comb begin
        go_r   = (state_reg == GO_REQ);
        done_a = (state_reg == DONE_ACK);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            reg_ack_reg      <= 1'b0;
            ap_start_reg     <= 1'b0;
            ap_done_reg      <= 1'b0;
            ap_ready_reg     <= 1'b0;
            auto_restart_reg <= 1'b0;
            gie_reg          <= 1'b0;
            ier_reg          <= 2'b00;
            isr_reg          <= 2'b00;
            interrupt_reg    <= 1'b0;
        end else begin
            reg_ack_reg <= reg_req & ~reg_ack_reg;
            // A host start in the same cycle as the launch ack must not be lost
            if (ready_evt)      ap_start_reg <= auto_restart_reg | start_set;
            else if (start_set) ap_start_reg <= 1'b1;
            if (wr_acc && hit_ctrl && reg_wstrb[0]) auto_restart_reg <= reg_wdata[7];
            if (done_evt)     ap_done_reg <= 1'b1;
            else if (ctrl_rd) ap_done_reg <= 1'b0;
            if (ready_evt)    ap_ready_reg <= 1'b1;
            else if (ctrl_rd) ap_ready_reg <= 1'b0;
            if (wr_acc && hit_gie && reg_wstrb[0]) gie_reg <= reg_wdata[0];
            if (wr_acc && hit_ier && reg_wstrb[0]) ier_reg <= reg_wdata[1:0];
            isr_reg       <= (isr_reg ^ isr_toggle) | {ready_evt, done_evt};
            interrupt_reg <= gie_reg & |(isr_reg & ier_reg);
        end
    end

    // Argument snapshot is taken on the IDLE->GO_REQ transition and held for the run
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_ARGS; i++) begin
                arg_reg[i]      <= '0;
                arg_snap_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ARGS; i++) begin
                if (wr_acc && hit_lo[i])
                    arg_reg[i][31:0] <= merge_bytes(arg_reg[i][31:0], reg_wdata, reg_wstrb);
                if (wr_acc && hit_hi[i])
                    arg_reg[i][63:32] <= merge_bytes(arg_reg[i][63:32], reg_wdata, reg_wstrb);
                if (launch)
                    arg_snap_reg[i] <= arg_reg[i];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (hit_ctrl) rd_mux = {24'b0, auto_restart_reg, 3'b0, ap_ready_reg, ap_idle, ap_done_reg, ap_start_reg};
        if (hit_gie)  rd_mux = {31'b0, gie_reg};
        if (hit_ier)  rd_mux = {30'b0, ier_reg};
        if (hit_isr)  rd_mux = {30'b0, isr_reg};
        for (int i = 0; i < NUM_ARGS; i++) begin
            if (hit_lo[i]) rd_mux = arg_reg[i][31:0];
            if (hit_hi[i]) rd_mux = arg_reg[i][63:32];
        end
    end

    assign reg_rdata = reg_ack_reg ? rd_mux : 32'h0;
    assign reg_ack   = reg_ack_reg;
    assign interrupt = interrupt_reg;

endmodule

// File: tb/tb_sda_kernel_ctrl_reg_multi.sv
// Bench for sda_kernel_ctrl_reg_multi: register table, randomized register traffic
// against a register-file model, and hand-written launch/done handshake sequences.
module tb_sda_kernel_ctrl_reg_multi;

    localparam int AW = 6;
    localparam int NA = 2;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n = 1'b0;
    logic            reg_req = 1'b0;
    logic            reg_ack;
    logic            reg_write_en = 1'b0;
    logic [AW-1:0]   reg_addr = '0;
    logic [31:0]     reg_wdata = '0;
    logic [3:0]      reg_wstrb = '0;
    logic [31:0]     reg_rdata;
    logic            go_r;
    logic            go_a = 1'b0;
    logic            done_r = 1'b0;
    logic            done_a;
    logic            interrupt;
    logic [64*NA-1:0] arg_base;

    sda_kernel_ctrl_reg_multi #(.ADDR_WIDTH(AW), .NUM_ARGS(NA)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .reg_req(reg_req), .reg_ack(reg_ack), .reg_write_en(reg_write_en),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
        .reg_rdata(reg_rdata),
        .go_r(go_r), .go_a(go_a), .done_r(done_r), .done_a(done_a),
        .interrupt(interrupt), .arg_base(arg_base)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [22];
    logic [31:0] rd;
    logic [31:0] m    [16];
    logic [31:0] mask [16];
    logic [3:0]  rw;
    logic [1:0]  rlo;
    logic [31:0] rwd, exp_v;
    logic [3:0]  rstrb;
    logic        rwr;

    function automatic vec_t mk(input logic wr, input logic [5:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [31:0] exp);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic bus(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output logic [31:0] rdata);
        int n;
        n = 0;
        reg_req = 1'b1; reg_write_en = wr; reg_addr = addr; reg_wdata = data; reg_wstrb = strb;
        do begin
            tick();
            n++;
        end while (!reg_ack && n < 20);
        if (!reg_ack) begin
            checks++; errors++;
            $display("FAIL bus_ack: no ack after %0d cycles at addr 0x%0h", n, addr);
        end
        rdata = reg_rdata;
        tick();
        reg_req = 1'b0; reg_write_en = 1'b0;
        check("ack_single_pulse", reg_ack, 1'b0);
        $display("bus %s addr=0x%02h wdata=0x%08h strb=%b rdata=0x%08h", wr ? "WR" : "RD", addr, data, strb, rdata);
    endtask

    task automatic wr_reg(input logic [AW-1:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        bus(1'b1, addr, data, 4'hF, dummy);
    endtask

    task automatic rd_check(input string name, input logic [AW-1:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        bus(1'b0, addr, 32'h0, 4'h0, v);
        check(name, v, exp);
    endtask

    // sel 0 watches go_r, sel 1 watches done_a
    task automatic wait_sig(input string name, input int sel, input logic val);
        int n;
        logic s;
        n = 0;
        s = (sel == 0) ? go_r : done_a;
        while (s !== val && n < 50) begin
            tick();
            n++;
            s = (sel == 0) ? go_r : done_a;
        end
        if (s !== val) begin
            checks++; errors++;
            $display("FAIL %s: timed out waiting for %0b", name, val);
        end
    endtask

    task automatic launch_ack();
        wait_sig("go_r_rise", 0, 1'b1);
        go_a = 1'b1;
        wait_sig("go_r_fall", 0, 1'b0);
        go_a = 1'b0;
        tick();
    endtask

    task automatic finish_run();
        done_r = 1'b1;
        wait_sig("done_a_rise", 1, 1'b1);
        done_r = 1'b0;
        wait_sig("done_a_fall", 1, 1'b0);
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0; go_a = 1'b0; done_r = 1'b0; reg_req = 1'b0;
        tick();
        tick();
        ap_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = mk(0, 6'h00, 32'h0,        4'h0, 32'h4);
        tbl[1]  = mk(0, 6'h04, 32'h0,        4'h0, 32'h0);
        tbl[2]  = mk(1, 6'h04, 32'hFFFFFFFF, 4'hF, 32'h0);
        tbl[3]  = mk(0, 6'h04, 32'h0,        4'h0, 32'h1);
        tbl[4]  = mk(1, 6'h08, 32'h00000007, 4'hF, 32'h0);
        tbl[5]  = mk(0, 6'h08, 32'h0,        4'h0, 32'h3);
        tbl[6]  = mk(1, 6'h10, 32'h11223344, 4'h5, 32'h0);
        tbl[7]  = mk(0, 6'h10, 32'h0,        4'h0, 32'h00220044);
        tbl[8]  = mk(1, 6'h14, 32'hAABBCCDD, 4'hF, 32'h0);
        tbl[9]  = mk(0, 6'h17, 32'h0,        4'h0, 32'hAABBCCDD);
        tbl[10] = mk(1, 6'h0C, 32'h00000003, 4'h1, 32'h0);
        tbl[11] = mk(0, 6'h0C, 32'h0,        4'h0, 32'h3);
        tbl[12] = mk(1, 6'h0C, 32'h00000001, 4'h1, 32'h0);
        tbl[13] = mk(0, 6'h0C, 32'h0,        4'h0, 32'h2);
        tbl[14] = mk(1, 6'h0C, 32'h00000002, 4'h0, 32'h0);
        tbl[15] = mk(0, 6'h0C, 32'h0,        4'h0, 32'h2);
        tbl[16] = mk(1, 6'h20, 32'hDEADBEEF, 4'hF, 32'h0);
        tbl[17] = mk(0, 6'h20, 32'h0,        4'h0, 32'h0);
        tbl[18] = mk(0, 6'h18, 32'h0,        4'h0, 32'h0);
        tbl[19] = mk(1, 6'h08, 32'h000000FF, 4'h0, 32'h0);
        tbl[20] = mk(0, 6'h08, 32'h0,        4'h0, 32'h3);
        tbl[21] = mk(0, 6'h00, 32'h0,        4'h0, 32'h4);

        // Reset state
        do_reset();
        check("rst_go_r", go_r, 1'b0);
        check("rst_done_a", done_a, 1'b0);
        check("rst_interrupt", interrupt, 1'b0);
        check("rst_arg_base", arg_base, '0);
        check("rst_rdata_idle", reg_rdata, 32'h0);

        // Register table
        for (int i = 0; i < 22; i++) begin
            bus(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, rd);
            if (!tbl[i].wr) check($sformatf("table_rd[%0d]", i), rd, tbl[i].exp);
        end

        // Randomized register traffic against a plain register-file model
        do_reset();
        for (int w = 0; w < 16; w++) begin
            m[w] = 32'h0;
            mask[w] = (w == 1) ? 32'h1 : (w == 2) ? 32'h3 : (w >= 4 && w < 4 + 2*NA) ? 32'hFFFFFFFF : 32'h0;
        end
        for (int k = 0; k < 60; k++) begin
            rw    = 4'($urandom_range(15));
            rlo   = 2'($urandom_range(3));
            rwd   = $urandom;
            rstrb = 4'($urandom_range(15));
            rwr   = ($urandom_range(1) == 1) && (rw != 4'd0);
            bus(rwr, {rw, rlo}, rwd, rstrb, rd);
            if (rwr) begin
                if (rw == 4'd3) begin
                    if (rstrb[0]) m[3][1:0] = m[3][1:0] ^ rwd[1:0];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (rstrb[b]) m[rw][8*b +: 8] = rwd[8*b +: 8];
                    m[rw] = m[rw] & mask[rw];
                end
            end else begin
                exp_v = (rw == 4'd0) ? 32'h4 : m[rw];
                check($sformatf("rand_rd[%0d] addr=0x%0h", k, {rw, rlo}), rd, exp_v);
            end
            tick();
            check($sformatf("rand_irq[%0d]", k), interrupt, m[1][0] & (|(m[3][1:0] & m[2][1:0])));
        end
        check("rand_no_launch", arg_base, '0);

        // Launch with arguments, done/ready status and clear-on-read
        do_reset();
        wr_reg(6'h10, 32'h23456780);
        wr_reg(6'h14, 32'h00000001);
        wr_reg(6'h18, 32'hCAFEF00D);
        wr_reg(6'h1C, 32'h0BADBEEF);
        wr_reg(6'h00, 32'h00000001);
        wait_sig("launch_go_r", 0, 1'b1);
        check("launch_arg0", arg_base[63:0], 64'h0000000123456780);
        check("launch_arg1", arg_base[127:64], 64'h0BADBEEFCAFEF00D);
        launch_ack();
        finish_run();
        rd_check("ctrl_done", 6'h00, 32'hE);
        rd_check("ctrl_cleared", 6'h00, 32'h4);
        rd_check("isr_after_run", 6'h0C, 32'h3);

        // Interrupt timing
        wr_reg(6'h0C, 32'h3);
        wr_reg(6'h04, 32'h1);
        wr_reg(6'h08, 32'h1);
        wr_reg(6'h00, 32'h1);
        launch_ack();
        done_r = 1'b1;
        wait_sig("irq_done_a", 1, 1'b1);
        check("irq_not_yet", interrupt, 1'b0);
        tick();
        check("irq_set", interrupt, 1'b1);
        done_r = 1'b0;
        wait_sig("irq_idle", 1, 1'b0);
        rd_check("irq_ctrl", 6'h00, 32'hE);
        wr_reg(6'h0C, 32'h1);
        check("irq_hold_one_cycle", interrupt, 1'b1);
        tick();
        check("irq_cleared", interrupt, 1'b0);
        rd_check("isr_toggled", 6'h0C, 32'h2);

        // Argument writes during a run do not reach arg_base until the next launch
        wr_reg(6'h10, 32'h55);
        wr_reg(6'h14, 32'h0);
        wr_reg(6'h00, 32'h1);
        launch_ack();
        check("snap_first", arg_base[63:0], 64'h55);
        wr_reg(6'h10, 32'hAA);
        check("snap_held", arg_base[63:0], 64'h55);
        finish_run();
        check("snap_after_done", arg_base[63:0], 64'h55);
        rd_check("snap_ctrl1", 6'h00, 32'hE);
        wr_reg(6'h00, 32'h1);
        launch_ack();
        check("snap_next", arg_base[63:0], 64'hAA);
        finish_run();
        rd_check("snap_ctrl2", 6'h00, 32'hE);

        // Auto-restart relaunches without a host write, then stops when cleared
        wr_reg(6'h00, 32'h81);
        launch_ack();
        finish_run();
        tick();
        check("auto_relaunch", go_r, 1'b1);
        wr_reg(6'h00, 32'h00);
        launch_ack();
        finish_run();
        repeat (4) tick();
        check("auto_stopped", go_r, 1'b0);
        rd_check("auto_ctrl", 6'h00, 32'hE);

        // CTRL read coincident with the done event keeps ap_done set
        wr_reg(6'h00, 32'h1);
        launch_ack();
        reg_req = 1'b1; reg_write_en = 1'b0; reg_addr = 6'h00;
        tick();
        check("coinc_ack", reg_ack, 1'b1);
        check("coinc_rdata", reg_rdata, 32'h8);
        done_r = 1'b1;
        tick();
        reg_req = 1'b0;
        done_r = 1'b0;
        wait_sig("coinc_idle", 1, 1'b0);
        rd_check("coinc_done_kept", 6'h00, 32'h6);

        // Asynchronous reset while the action holds done
        wr_reg(6'h00, 32'h1);
        launch_ack();
        check("pre_rst_irq", interrupt, 1'b1);
        done_r = 1'b1;
        wait_sig("pre_rst_done_a", 1, 1'b1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("async_rst_go_r", go_r, 1'b0);
        check("async_rst_done_a", done_a, 1'b0);
        check("async_rst_irq", interrupt, 1'b0);
        check("async_rst_arg_base", arg_base, '0);
        ap_rst_n = 1'b1;
        done_r = 1'b0;
        tick();
        rd_check("post_rst_ctrl", 6'h00, 32'h4);
        rd_check("post_rst_isr", 6'h0C, 32'h0);
        rd_check("post_rst_arg0", 6'h10, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
